// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states and default frame constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int UART_SIZE_DATA   = 8;
  localparam int UART_OVER_SAMPLE = 16;
  localparam int UART_MID_SAMPLE  = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meta <= 1'b1;
      o_q  <= 1'b1;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start/data/stop FSM sampling each bit at its mid-point.
// Define UART_RX_SYNC_EN to route i_rx_serial through a 2-flop synchronizer.
module uart_rx
  import uart_pkg::*;
#(
  parameter int SIZE_DATA   = UART_SIZE_DATA,
  parameter int OVER_SAMPLE = UART_OVER_SAMPLE,
  parameter int MID_SAMPLE  = UART_MID_SAMPLE
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_stick,
  input  logic                 i_rx_serial,
  output logic [SIZE_DATA-1:0] o_rx_data,
  output logic                 o_rx_done,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int TW = $clog2(OVER_SAMPLE);
  localparam int BW = $clog2(SIZE_DATA + 1);
  localparam logic [TW-1:0] TICK_MID = TW'(MID_SAMPLE - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVER_SAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(SIZE_DATA - 1);

  logic rx;

`ifdef UART_RX_SYNC_EN
  uart_rx_sync u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_rx_serial),
    .o_q   (rx)
  );
`else
  assign rx = i_rx_serial;
`endif

  uart_state_e          state;
  logic [TW-1:0]        tick;
  logic [BW-1:0]        bit_cnt;
  logic [SIZE_DATA-1:0] shift;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      tick        <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      o_rx_data   <= '0;
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
      case (state)
        // start detection is per clock, so a start right after a stop mid-point is caught
        IDLE: if (!rx) begin
          state  <= START;
          tick   <= '0;
          o_busy <= 1'b1;
        end
        START: if (i_stick) begin
          if (tick == TICK_MID) begin
            tick <= '0;
            if (!rx) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end
          end else begin
            tick <= tick + TW'(1);
          end
        end
        DATA: if (i_stick) begin
          if (tick == TICK_END) begin
            tick    <= '0;
            shift   <= {rx, shift[SIZE_DATA-1:1]};
            bit_cnt <= bit_cnt + BW'(1);
            if (bit_cnt == BIT_LAST) state <= STOP;
          end else begin
            tick <= tick + TW'(1);
          end
        end
        STOP: if (i_stick) begin
          if (tick == TICK_END) begin
            tick   <= '0;
            state  <= IDLE;
            o_busy <= 1'b0;
            if (rx) begin
              o_rx_data <= shift;
              o_rx_done <= 1'b1;
            end else begin
              o_frame_err <= 1'b1;
            end
          end else begin
            tick <= tick + TW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter SIZE_DATA, default 8, data bits per frame.
REQ-002 SHALL have parameter OVER_SAMPLE, default 16, stick pulses per bit period.
REQ-003 SHALL have parameter MID_SAMPLE, default 8, stick pulses from start-bit falling edge to start-bit mid-point.
REQ-004 SHALL have port i_clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port i_stick  input  1  one-clock oversample tick from baud_generator (BAUD x OVER_SAMPLE).
REQ-007 SHALL have port i_rx_serial  input  1  serial line; idle high; frame is start(0), SIZE_DATA bits LSB first, stop(1).
REQ-008 SHALL have port o_rx_data  output  SIZE_DATA  last correctly framed byte.
REQ-009 SHALL have port o_rx_done  output  1  one-clock pulse when o_rx_data is updated.
REQ-010 SHALL have port o_frame_err  output  1  one-clock pulse when the stop bit samples 0.
REQ-011 SHALL have port o_busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-013 SHALL use a tick counter (width clog2(OVER_SAMPLE)) that advances only on clocks where i_stick=1.
REQ-014 In IDLE, rx=0 SHALL move the FSM to START and clear the tick counter.
REQ-015 In START, at tick MID_SAMPLE-1: rx=0 SHALL clear the counter and enter DATA; rx=1 SHALL return to IDLE with no output pulse (false start).
REQ-016 In DATA, at tick OVER_SAMPLE-1 SHALL shift rx into the MSB of the shift register (LSB-first reception), clear the counter and increment a bit counter.
REQ-017 After the SIZE_DATA-th data sample SHALL enter STOP.
REQ-018 In STOP, at tick OVER_SAMPLE-1: rx=1 SHALL load o_rx_data from the shift register and pulse o_rx_done; rx=0 SHALL pulse o_frame_err and leave o_rx_data unchanged; both cases enter IDLE on the same edge.
REQ-019 o_rx_done and o_frame_err SHALL never be high in the same cycle and SHALL be high for exactly one clock.
REQ-020 A start bit beginning immediately after the stop-bit mid-point SHALL be detected (back-to-back frames, no idle gap).
REQ-021 Latency from stop-bit mid-point sample to o_rx_done SHALL be 1 clock (registered output), plus the synchronizer delay of REQ-025 when enabled.

Reset
REQ-022 Asserting i_rst SHALL asynchronously force IDLE, clear tick/bit counters and shift register, o_rx_data=0, o_rx_done=0, o_frame_err=0, o_busy=0.
REQ-023 Reset asserted mid-frame SHALL discard the partial frame; reception SHALL restart at the next falling edge after release.

Configuration
REQ-024 Macro UART_RX_SYNC_EN SHALL select the input path.
REQ-025 With UART_RX_SYNC_EN defined: i_rx_serial SHALL pass through a 2-flop synchronizer reset to 1, adding 2 clocks of latency to all sampling.
REQ-026 Without UART_RX_SYNC_EN: i_rx_serial SHALL be used directly (caller guarantees synchronous input).

Structure
REQ-027 Package uart_pkg SHALL hold the FSM state enum typedef and default constants SIZE_DATA/OVER_SAMPLE/MID_SAMPLE, shared with Transmitter.
REQ-028 The synchronizer SHALL be sub-module uart_rx_sync (2-flop, async active-high reset to 1), instantiated only under UART_RX_SYNC_EN.

Verification (50 MHz clk, baud_generator BAUDRATE_VALUE=325, OVER_SAMPLE=16)
REQ-029 Loopback Transmitter sending 0x55 -> exactly one o_rx_done, o_rx_data=0x55, o_frame_err never high.
REQ-030 Bench-driven frame 0xA3 -> o_rx_data=0xA3, o_rx_done one clock wide, o_busy low after the stop-bit mid-point.
REQ-031 Low glitch of 4 stick periods on idle line -> no o_rx_done, no o_frame_err, o_busy falls at tick MID_SAMPLE-1.
REQ-032 Frame 0xFF (after prior 0x12) with stop bit driven 0 -> o_frame_err pulse, o_rx_data stays 0x12.
REQ-033 i_rst pulsed during bit 3 of a frame -> all outputs 0 immediately; next frame 0x3C -> o_rx_data=0x3C.
REQ-034 Back-to-back frames 0x01, 0x80 with no idle gap -> two o_rx_done pulses, data 0x01 then 0x80.
